// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with a one-entry output buffer,
// redirect draining, halt handling and an unacknowledged-request timeout.
//
// state   | meaning
// FETCH   | issuing and completing requests into the output buffer
// DRAIN   | redirect arrived mid-request; waiting for the ack to discard it
// HALTED  | halt held, no requests; redirects still move the PC
// ERROR   | misaligned target or timeout; absorbing until reset
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          MAX_WAIT     = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        fetch_err
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic          r_run;
    logic          r_out;
    logic          r_valid;
    logic          r_err;
    logic          r_tgt_bad;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [31:0]   r_instr_pc;
    logic [31:0]   r_tgt;
    logic [WW-1:0] r_wait;

    logic          w_issue;
    logic          w_ack;
    logic          w_timeout;
    logic          w_misalign;
    logic          w_drain;
    logic          w_hold;
    logic          w_valid_n;
    logic          w_tgt_bad_n;
    logic          w_eff_bad;
    logic [31:0]   w_pc_n;
    logic [31:0]   w_instr_n;
    logic [31:0]   w_instr_pc_n;
    logic [31:0]   w_tgt_n;
    logic [31:0]   w_eff_tgt;

    // A fresh request is raised combinationally so that a draining buffer
    // can be refilled without a bubble; r_out keeps it up until the ack.
    assign w_issue    = r_run && (r_state == ST_FETCH) && !r_out && !halt &&
                        !redirect_valid && (!r_valid || instr_ready);
    assign imem_req   = r_out | w_issue;
    assign imem_addr  = r_pc;
    assign w_ack      = imem_req & imem_ack;
    assign w_timeout  = imem_req & ~imem_ack & (r_wait == WAIT_LAST);
    assign w_misalign = |redirect_target[1:0];
    assign w_drain    = r_valid & instr_ready;
    assign w_hold     = r_out & ~imem_ack;

    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_err   = r_err;

    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_valid_n    = r_valid;
        w_instr_n    = r_instr;
        w_instr_pc_n = r_instr_pc;
        w_tgt_n      = r_tgt;
        w_tgt_bad_n  = r_tgt_bad;
        w_eff_tgt    = r_tgt;
        w_eff_bad    = r_tgt_bad;

        case (r_state)
            ST_FETCH: begin
                if (w_timeout) begin
                    w_state_n = ST_ERROR;
                end else if (redirect_valid) begin
                    if (w_hold) begin
                        w_tgt_n     = redirect_target;
                        w_tgt_bad_n = w_misalign;
                        w_valid_n   = 1'b0;
                        w_state_n   = ST_DRAIN;
                    end else if (w_misalign) begin
                        w_state_n = ST_ERROR;
                    end else begin
                        w_pc_n    = redirect_target;
                        w_valid_n = 1'b0;
                    end
                end else begin
                    if (w_ack) begin
                        w_instr_n    = imem_rdata;
                        w_instr_pc_n = r_pc;
                        w_pc_n       = r_pc + 32'd4;
                        w_valid_n    = 1'b1;
                    end else if (w_drain) begin
                        w_valid_n = 1'b0;
                    end
                    if (halt && !w_hold) begin
                        w_state_n = ST_HALTED;
                    end
                end
            end

            ST_DRAIN: begin
                if (w_drain) begin
                    w_valid_n = 1'b0;
                end
                if (redirect_valid) begin
                    w_eff_tgt = redirect_target;
                    w_eff_bad = w_misalign;
                end
                w_tgt_n     = w_eff_tgt;
                w_tgt_bad_n = w_eff_bad;
                if (w_timeout) begin
                    w_state_n = ST_ERROR;
                end else if (w_ack) begin
                    if (w_eff_bad) begin
                        w_state_n = ST_ERROR;
                    end else begin
                        w_pc_n    = w_eff_tgt;
                        w_state_n = ST_FETCH;
                    end
                end
            end

            ST_HALTED: begin
                if (w_drain) begin
                    w_valid_n = 1'b0;
                end
                if (redirect_valid && w_misalign) begin
                    w_state_n = ST_ERROR;
                end else begin
                    if (redirect_valid) begin
                        w_pc_n    = redirect_target;
                        w_valid_n = 1'b0;
                    end
                    if (!halt) begin
                        w_state_n = ST_FETCH;
                    end
                end
            end

            ST_ERROR: begin
                w_state_n = ST_ERROR;
            end

            default: begin
                w_state_n = ST_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_FETCH;
            r_run      <= 1'b0;
            r_out      <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_tgt_bad  <= 1'b0;
            r_pc       <= RESET_VECTOR;
            r_instr    <= 32'h0;
            r_instr_pc <= 32'h0;
            r_tgt      <= 32'h0;
            r_wait     <= '0;
        end else begin
            r_state    <= w_state_n;
            r_run      <= 1'b1;
            r_out      <= imem_req & ~imem_ack & (w_state_n != ST_ERROR);
            r_valid    <= w_valid_n;
            r_err      <= r_err | (w_state_n == ST_ERROR);
            r_tgt_bad  <= w_tgt_bad_n;
            r_pc       <= w_pc_n;
            r_instr    <= w_instr_n;
            r_instr_pc <= w_instr_pc_n;
            r_tgt      <= w_tgt_n;
            r_wait     <= (imem_req & ~imem_ack) ? r_wait + WW'(1) : '0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        fetch_err;
    logic [31:0] salt;

    int n_vec = 0;
    int n_err = 0;

    assign imem_rdata = imem_addr ^ salt;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_VECTOR(RV), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt), .fetch_err(fetch_err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_idle();
        imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; halt = 1'b0;
    endtask

    // Leaves the caller at the drive point of the first cycle after reset.
    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RV) begin n_err++;
            $display("FAIL first_req: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RV); end
        @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
        imem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RV + 32'hC) begin n_err++;
            $display("FAIL pre_reset_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, RV + 32'hC); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_err++;
            $display("FAIL rst_req: got %b want 0", imem_req); end
        n_vec++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin n_err++;
            $display("FAIL rst_buf: valid=%b instr=%h pc=%h want 0 0 0", instr_valid, instr, instr_pc); end
        n_vec++; if (fetch_err !== 1'b0 || imem_addr !== RV) begin n_err++;
            $display("FAIL rst_err_pc: err=%b addr=%h want 0 %h", fetch_err, imem_addr, RV); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RV) begin n_err++;
            $display("FAIL rst_restart: req=%b addr=%h want 1 %h", imem_req, imem_addr, RV); end
    endtask

    task automatic test_sequence();
        logic [31:0] exp;
        do_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = RV + 32'(4 * k);
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== exp) begin n_err++;
                $display("FAIL seq_addr[%0d]: req=%b addr=%h want 1 %h", k, imem_req, imem_addr, exp); end
            if (k > 0) begin
                n_vec++; if (instr_valid !== 1'b1 || instr_pc !== exp - 32'd4 || instr !== ((exp - 32'd4) ^ salt)) begin
                    n_err++;
                    $display("FAIL seq_trail[%0d]: valid=%b pc=%h instr=%h want 1 %h %h",
                             k, instr_valid, instr_pc, instr, exp - 32'd4, (exp - 32'd4) ^ salt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_ack = 1'b1; instr_ready = 1'b0;
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_vec++; if (imem_req !== 1'b0) begin n_err++;
                $display("FAIL stall_req[%0d]: got %b want 0", j, imem_req); end
            n_vec++; if (instr_valid !== 1'b1 || instr_pc !== RV || instr !== (RV ^ salt)) begin n_err++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h want 1 %h %h",
                         j, instr_valid, instr_pc, instr, RV, RV ^ salt); end
            @(posedge clk); #1;
        end
        instr_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RV + 32'd4) begin n_err++;
            $display("FAIL stall_release: req=%b addr=%h want 1 %h", imem_req, imem_addr, RV + 32'd4); end
        @(posedge clk); #1;
    endtask

    task automatic test_redirect_drain();
        do_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_target = 32'h100;
        for (int j = 0; j < 3; j++) begin
            if (j == 2) imem_ack = 1'b1;
            @(negedge clk);
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++;
                $display("FAIL drain_addr[%0d]: req=%b addr=%h want 1 00000008", j, imem_req, imem_addr); end
            @(posedge clk); #1;
            redirect_valid = 1'b0;
        end
        imem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++;
            $display("FAIL drain_target: req=%b addr=%h want 1 00000100", imem_req, imem_addr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++;
            $display("FAIL drain_dropped: valid=%b want 0", instr_valid); end
    endtask

    task automatic test_misalign();
        do_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_ack = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h102;
        @(negedge clk);
        n_vec++; if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin n_err++;
            $display("FAIL mis_before: err=%b req=%b want 0 0", fetch_err, imem_req); end
        @(posedge clk); #1;
        redirect_valid = 1'b0; instr_ready = 1'b1; imem_ack = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_vec++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h8) begin n_err++;
                $display("FAIL mis_error[%0d]: err=%b req=%b pc=%h want 1 0 00000008",
                         j, fetch_err, imem_req, imem_addr); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        imem_ack = 1'b0; instr_ready = 1'b1;
        for (int j = 0; j < MW; j++) begin
            @(negedge clk);
            n_vec++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin n_err++;
                $display("FAIL to_wait[%0d]: req=%b err=%b want 1 0", j, imem_req, fetch_err); end
            @(posedge clk); #1;
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_vec++; if (imem_req !== 1'b0 || fetch_err !== 1'b1) begin n_err++;
                $display("FAIL to_error[%0d]: req=%b err=%b want 0 1", j, imem_req, fetch_err); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        bit found;
        do_reset();
        imem_ack = 1'b0; instr_ready = 1'b1;
        @(posedge clk); #1;
        halt = 1'b1;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== RV) begin n_err++;
            $display("FAIL halt_outstanding: req=%b addr=%h want 1 %h", imem_req, imem_addr, RV); end
        @(posedge clk); #1;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== RV || instr !== (RV ^ salt)) begin
            n_err++;
            $display("FAIL halt_buffered: req=%b valid=%b pc=%h instr=%h want 0 1 %h %h",
                     imem_req, instr_valid, instr_pc, instr, RV, RV ^ salt);
        end
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_target = 32'h40;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b0) begin n_err++;
            $display("FAIL halt_noreq: req=%b want 0", imem_req); end
        @(posedge clk); #1;
        redirect_valid = 1'b0; halt = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 4 && !found; j++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                found = 1'b1;
                n_vec++; if (imem_addr !== 32'h40) begin n_err++;
                    $display("FAIL halt_resume_addr: got %h want 00000040", imem_addr); end
            end
            @(posedge clk); #1;
        end
        n_vec++; if (!found) begin n_err++;
            $display("FAIL halt_resume: no request within 4 cycles, want request at 00000040"); end
    endtask

    // Model: expected fetch address, queue of (pc,data) owed downstream,
    // and whether the in-flight request's data must be thrown away.
    task automatic test_random();
        logic [31:0] exp_pc, tb_addr, s_addr, s_rdata;
        logic [31:0] q_pc[$];
        logic [31:0] q_dat[$];
        bit drop, tb_out, s_req, s_ack, s_valid, s_ready, s_rv;
        int cnt, dly;
        do_reset();
        exp_pc = RV; drop = 1'b0; tb_out = 1'b0; tb_addr = 32'h0; cnt = 0; dly = 0;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            redirect_valid  = ($urandom_range(0, 11) == 0);
            redirect_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            imem_ack = 1'b0;
            @(negedge clk);
            s_req = imem_req; s_addr = imem_addr;
            if (tb_out) begin
                n_vec++; if (s_req !== 1'b1 || s_addr !== tb_addr) begin n_err++;
                    $display("FAIL rnd_hold[%0d]: req=%b addr=%h want 1 %h", i, s_req, s_addr, tb_addr); end
            end else if (s_req) begin
                n_vec++; if (s_addr !== exp_pc) begin n_err++;
                    $display("FAIL rnd_addr[%0d]: got %h want %h", i, s_addr, exp_pc); end
                n_vec++; if (halt !== 1'b0 || (instr_valid & ~instr_ready) !== 1'b0) begin n_err++;
                    $display("FAIL rnd_issue_rule[%0d]: halt=%b full_stalled=%b want 0 0",
                             i, halt, instr_valid & ~instr_ready); end
                dly = $urandom_range(0, 2); cnt = 0;
            end
            imem_ack = s_req && (cnt >= dly);
            #1;
            s_ack = imem_ack; s_rdata = imem_rdata; s_valid = instr_valid;
            s_ready = instr_ready; s_rv = redirect_valid;
            if (s_valid && s_ready) begin
                n_vec++;
                if (q_pc.size() == 0) begin n_err++;
                    $display("FAIL rnd_spurious[%0d]: valid=1 pc=%h want no instruction", i, instr_pc); end
                else if (instr_pc !== q_pc[0] || instr !== q_dat[0]) begin n_err++;
                    $display("FAIL rnd_data[%0d]: pc=%h instr=%h want %h %h", i, instr_pc, instr, q_pc[0], q_dat[0]); end
            end
            @(posedge clk);
            if (s_valid && s_ready && q_pc.size() > 0) begin
                void'(q_pc.pop_front()); void'(q_dat.pop_front());
            end
            if (s_rv) begin
                q_pc.delete(); q_dat.delete();
                exp_pc = redirect_target;
                drop = s_req & ~s_ack;
            end else if (s_req && s_ack) begin
                if (drop) drop = 1'b0;
                else begin
                    q_pc.push_back(s_addr); q_dat.push_back(s_rdata);
                    exp_pc = s_addr + 32'd4;
                end
            end
            tb_out = s_req & ~s_ack;
            if (tb_out) begin tb_addr = s_addr; cnt++; end
            #1;
            n_vec++; if (instr_valid !== (q_pc.size() != 0) || fetch_err !== 1'b0) begin n_err++;
                $display("FAIL rnd_state[%0d]: valid=%b err=%b want %b 0", i, instr_valid, fetch_err, q_pc.size() != 0); end
        end
    endtask

    initial begin
        salt = 32'hA5A5_0000 | $urandom;
        reset = 1'b0;
        drive_idle();
        test_reset();
        test_sequence();
        test_backpressure();
        test_redirect_drain();
        test_misalign();
        test_timeout();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 15, maximum cycles a memory request may stay unacknowledged.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 imem_req  output  1  instruction memory request.
REQ-006 imem_addr  output  32  request address.
REQ-007 imem_ack  input  1  memory accepts and completes the request this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 instr_valid  output  1  output buffer holds an instruction.
REQ-010 instr  output  32  buffered instruction.
REQ-011 instr_pc  output  32  address of the buffered instruction.
REQ-012 instr_ready  input  1  downstream accepts the buffer this cycle.
REQ-013 redirect_valid  input  1  branch/jump redirect request.
REQ-014 redirect_target  input  32  redirect destination.
REQ-015 halt  input  1  level request to stop fetching.
REQ-016 fetch_err  output  1  sticky error: misaligned target or timeout.

Function
REQ-017 The block SHALL hold the PC register, a one-entry output buffer, a wait counter, and a state machine with states FETCH, DRAIN, HALTED, ERROR.
REQ-018 imem_addr SHALL equal the PC whenever imem_req=1, and SHALL stay stable from assertion until the ack cycle.
REQ-019 Once asserted, imem_req SHALL stay high until imem_ack=1; the ack cycle completes the request.
REQ-020 In FETCH, a new request SHALL be issued only when halt=0 and the buffer is empty or is being drained (instr_valid & instr_ready) in the same cycle.
REQ-021 In FETCH, on ack with no redirect, the block SHALL load instr<=imem_rdata, instr_pc<=PC and PC<=PC+4 (modulo 2^32); instr_valid SHALL be 1 from the next cycle.
REQ-022 The buffer SHALL clear when instr_valid & instr_ready and no new ack arrives that cycle.
REQ-023 On a redirect with no request outstanding, the block SHALL set PC<=redirect_target and clear the buffer; a transfer in that same cycle counts as accepted.
REQ-024 On a redirect coinciding with imem_ack, the block SHALL discard the returned data, set PC<=target, clear the buffer and remain in FETCH.
REQ-025 On a redirect while a request is outstanding without ack, the block SHALL latch the target and enter DRAIN.
  - DRAIN keeps imem_req and imem_addr unchanged.
  - On ack, the data is discarded, PC<=latched target, and the block returns to FETCH.
  - A further redirect in DRAIN overwrites the latched target.
REQ-026 A redirect_target with bits[1:0]!=0 SHALL be ignored for PC update; the block SHALL set fetch_err=1 and enter ERROR (after the DRAIN ack if a request is outstanding).
REQ-027 The wait counter SHALL count the cycles imem_req=1 without ack, reset on each ack.
  - When the count reaches MAX_WAIT, the block SHALL deassert imem_req, set fetch_err=1 and enter ERROR.
REQ-028 ERROR SHALL be absorbing until reset: imem_req=0, buffer frozen, fetch_err=1.
REQ-029 halt=1 SHALL block new requests; any outstanding request completes and its data is buffered normally; the block then enters HALTED.
REQ-030 In HALTED, imem_req=0 and redirects still update the PC; on halt=0, the block SHALL return to FETCH on the next cycle.
REQ-031 Priority SHALL be: ERROR > redirect > halt > normal fetch.

Reset
REQ-032 While reset=0, the outputs SHALL be forced asynchronously to: PC=RESET_VECTOR, state=FETCH, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_err=0, wait counter=0.
REQ-033 On the first rising clk edge after reset rises, imem_req=1 with imem_addr=RESET_VECTOR.
REQ-034 Reset asserted mid-request SHALL abandon the request without waiting for ack.

Verification
REQ-035 Reset release, ack every cycle, instr_ready=1 -> imem_addr sequence 0,4,8,C; instr_pc trails by one cycle.
REQ-036 instr_ready=0 with a full buffer -> imem_req=0 and instr/instr_pc held; ready=1 -> the next fetch issues the same cycle.
REQ-037 Redirect to 0x100 while request at 0x8 is unacked 3 cycles -> addr stays 0x8 until ack; data dropped; next request addr 0x100.
REQ-038 Redirect to 0x102 -> fetch_err=1, imem_req=0 permanently until reset; PC unchanged.
REQ-039 imem_ack held 0 with MAX_WAIT=4 -> imem_req drops after 4 cycles and fetch_err=1.
REQ-040 halt=1 during an outstanding request -> ack data buffered, then imem_req=0; redirect to 0x40 while halted, halt=0 -> next imem_addr=0x40.
